contador_m_updown: RTL and testbench

//  Parametrised modulo-M up/down counter; generalises the lab modulo-M counter.

---
 rtl/contador_m_updown_pkg.sv | 15 +
 rtl/contador_m_updown.sv | 82 ++++++++
 tb/tb_contador_m_updown.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/contador_m_updown_pkg.sv
// Shared codes and helpers for the modulo-M up/down counter.
// Direction codes plus a clog2 helper for deriving N from M.
package contador_m_updown_pkg;

  localparam logic SOBE  = 1'b0;
  localparam logic DESCE = 1'b1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/contador_m_updown.sv
// Modulo-M up/down counter with load, clear, compare and cascade carry.
// Define CONTADOR_SAT_EN to saturate at the ends instead of wrapping.
module contador_m_updown
  import contador_m_updown_pkg::*;
#(
  parameter int M = 100,
  parameter int N = 7
) (
  input  logic         clock,
  input  logic         zera_as_n,
  input  logic         zera_s,
  input  logic         carrega,
  input  logic [N-1:0] D,
  input  logic         conta,
  input  logic         desce,
  input  logic [N-1:0] cmp,
  output logic [N-1:0] Q,
  output logic         fim,
  output logic         meio,
  output logic         igual,
  output logic         vai
);

  localparam logic [N-1:0] MAXV  = N'(M - 1);
  localparam logic [N-1:0] MEIOV = N'(M / 2 - 1);

`ifdef CONTADOR_SAT_EN
  localparam logic [N-1:0] WRAP_UP = MAXV;
  localparam logic [N-1:0] WRAP_DN = '0;
`else
  localparam logic [N-1:0] WRAP_UP = '0;
  localparam logic [N-1:0] WRAP_DN = MAXV;
`endif

  logic [N-1:0] Q_q;
  logic [N-1:0] Q_d;

  always_ff @(posedge clock or negedge zera_as_n) begin
    if (!zera_as_n) Q_q <= '0;
    else            Q_q <= Q_d;
  end

  // Clear beats load beats count; out-of-range loads clamp to M-1.
  always_comb begin
    Q_d = Q_q;
    if (zera_s) begin
      Q_d = '0;
    end else if (carrega) begin
      Q_d = (D > MAXV) ? MAXV : D;
    end else if (conta) begin
      if (desce == DESCE) begin
        if (Q_q == '0) Q_d = WRAP_DN;
        else           Q_d = Q_q - 1'b1;
      end else begin
        if (Q_q >= MAXV) Q_d = WRAP_UP;
        else             Q_d = Q_q + 1'b1;
      end
    end
  end

  assign Q = Q_q;

  always_comb begin
    fim = 1'b0;
    if (desce == DESCE) fim = (Q_q == '0);
    else                fim = (Q_q >= MAXV);
  end

  always_comb begin
    meio  = (Q_q == MEIOV);
    igual = (Q_q == cmp);
  end

  always_comb begin
`ifdef CONTADOR_SAT_EN
    vai = 1'b0;
`else
    vai = conta & fim & ~zera_s & ~carrega;
`endif
  end

endmodule

// File: tb/tb_contador_m_updown.sv
// Scoreboard bench for contador_m_updown with M=10.
// Reference model uses plain modular arithmetic on an int.
module tb_contador_m_updown;
  import contador_m_updown_pkg::*;

  localparam int M = 10;
  localparam int N = clog2(M);

  typedef struct {
    int q;
    int fim;
    int meio;
    int igual;
    int vai;
  } exp_t;

  logic         clock;
  logic         zera_as_n;
  logic         zera_s;
  logic         carrega;
  logic [N-1:0] D;
  logic         conta;
  logic         desce;
  logic [N-1:0] cmp;
  logic [N-1:0] Q;
  logic         fim;
  logic         meio;
  logic         igual;
  logic         vai;

  int   n_chk;
  int   n_fail;
  int   q_m;
  exp_t sb[$];

  contador_m_updown #(.M(M), .N(N)) dut (
    .clock     (clock),
    .zera_as_n (zera_as_n),
    .zera_s    (zera_s),
    .carrega   (carrega),
    .D         (D),
    .conta     (conta),
    .desce     (desce),
    .cmp       (cmp),
    .Q         (Q),
    .fim       (fim),
    .meio      (meio),
    .igual     (igual),
    .vai       (vai)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input int act, input int req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic exp_t model_out(input int q);
    exp_t e;
    e.q     = q;
    e.fim   = desce ? int'(q == 0) : int'(q >= M - 1);
    e.meio  = int'(q == M / 2 - 1);
    e.igual = int'(q == int'(cmp));
`ifdef CONTADOR_SAT_EN
    e.vai   = 0;
`else
    e.vai   = int'(conta && e.fim == 1 && !zera_s && !carrega);
`endif
    return e;
  endfunction

  function automatic int model_next(input int q);
    int d;
    d = int'(D);
    if (zera_s) return 0;
    if (carrega) return (d > M - 1) ? M - 1 : d;
    if (!conta) return q;
`ifdef CONTADOR_SAT_EN
    if (desce) return (q == 0) ? 0 : q - 1;
    return (q >= M - 1) ? M - 1 : q + 1;
`else
    if (desce) return (q + M - 1) % M;
    return (q + 1) % M;
`endif
  endfunction

  // Called shortly after a rising edge; the edge that follows applies it.
  task automatic step(input bit zs, input bit ld, input int d,
                      input bit cn, input bit dn, input int cp);
    zera_s  = zs;
    carrega = ld;
    D       = N'(d);
    conta   = cn;
    desce   = dn;
    cmp     = N'(cp);
    sb.push_back(model_out(q_m));
    @(posedge clock);
    q_m = model_next(q_m);
    #1;
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("Q",     int'(Q),     e.q);
      chk("fim",   int'(fim),   e.fim);
      chk("meio",  int'(meio),  e.meio);
      chk("igual", int'(igual), e.igual);
      chk("vai",   int'(vai),   e.vai);
    end
  end

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    q_m       = 0;
    zera_as_n = 1'b0;
    zera_s    = 1'b0;
    carrega   = 1'b0;
    D         = '0;
    conta     = 1'b0;
    desce     = 1'b0;
    cmp       = '0;
    #12;
    chk("rst_Q",     int'(Q),     0);
    chk("rst_fim",   int'(fim),   0);
    chk("rst_igual", int'(igual), 1);
    desce = 1'b1;
    #1;
    chk("rst_fim_dn", int'(fim), 1);
    zera_as_n = 1'b1;
    @(posedge clock);
    #1;

    for (int i = 0; i < 12; i++) step(0, 0, 0, 1, 0, 5);
    step(0, 1, 2, 0, 0, 3);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1, 0);
    step(0, 1, 6, 1, 0, 6);
    step(0, 1, 15, 1, 1, 9);
    step(0, 0, 0, 1, 0, 9);
    step(0, 1, 7, 1, 0, 0);
    step(1, 1, 7, 1, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0, 5);
    step(0, 0, 0, 1, 1, 5);
    step(0, 0, 0, 0, 1, 4);

    step(0, 1, 7, 0, 0, 7);
    step(0, 0, 0, 0, 0, 7);
    #3;
    zera_as_n = 1'b0;
    #1;
    q_m = 0;
    chk("async_Q", int'(Q), 0);
    chk("async_fim", int'(fim), 0);
    #1;
    zera_as_n = 1'b1;
    @(posedge clock);
    #1;

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(15) == 0, $urandom_range(7) == 0,
           int'($urandom_range(15)), $urandom_range(3) != 0,
           $urandom_range(1) == 1, int'($urandom_range(M - 1)));
    end

    @(negedge clock);
    #1;
    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got %0d expected %0d", 1, 0);
    $fatal(1, "timeout");
  end

endmodule
